// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with majority-vote mid-bit sampling, sticky error flags and a
// first-word-fall-through byte FIFO drained through a valid/ready port.
`timescale 1ns/1ps
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 100,
    parameter int FIFO_AW      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rs232_rx,
    output logic [7:0]         rx_data,
    output logic               rx_valid,
    input  logic               rx_ready,
    output logic [FIFO_AW:0]   rx_level,
    output logic               frame_err,
    output logic               overflow,
    output logic               break_det,
    input  logic               err_clr
);

    // Handshake: a byte transfers on every rising clk edge where rx_valid && rx_ready;
    // rx_valid never depends on rx_ready and the head byte stays stable until taken.

    localparam int MID   = CLKS_PER_BIT / 2;
    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [15:0] CNT_S0   = 16'(MID - 1);
    localparam logic [15:0] CNT_S1   = 16'(MID);
    localparam logic [15:0] CNT_S2   = 16'(MID + 1);
    localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0] PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_IDLE
    } state_t;

    // Reset: asserted asynchronously, released two clocks after rst_n rises.
    logic [1:0] rst_pipe_q;
    logic [1:0] rst_pipe_d;
    logic       rst_int_n;

    always_comb begin
        rst_pipe_d = {rst_pipe_q[0], 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_pipe_q <= 2'b00;
        end else begin
            rst_pipe_q <= rst_pipe_d;
        end
    end

    assign rst_int_n = rst_pipe_q[1];

    logic rx_meta_q, rx_meta_d;
    logic rxs_q, rxs_d;

    always_comb begin
        rx_meta_d = rs232_rx;
        rxs_d     = rx_meta_q;
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx_meta_d;
            rxs_q     <= rxs_d;
        end
    end

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [1:0]  samp_q, samp_d;
    logic        maj;
    logic        push_req;
    logic        frame_set;
    logic        break_set;

    // Third vote is the live sample taken at CNT_S2.
    assign maj = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs_q) | (samp_q[1] & rxs_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        samp_d    = samp_q;
        push_req  = 1'b0;
        frame_set = 1'b0;
        break_set = 1'b0;

        if (cnt_q == CNT_S0) samp_d[0] = rxs_q;
        if (cnt_q == CNT_S1) samp_d[1] = rxs_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = 16'd0;
                if (!rxs_q) state_d = ST_START;
            end
            ST_START: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == CNT_S2 && maj) begin
                    state_d = ST_IDLE;
                    cnt_d   = 16'd0;
                end else if (cnt_q == CNT_LAST) begin
                    // Data bit periods are aligned to bit boundaries so their mid-bit votes line up.
                    state_d   = ST_DATA;
                    cnt_d     = 16'd0;
                    bit_idx_d = 3'd0;
                end
            end
            ST_DATA: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == CNT_S2) shreg_d = {maj, shreg_q[7:1]};
                if (cnt_q == CNT_LAST) begin
                    cnt_d = 16'd0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == CNT_S2) begin
                    cnt_d = 16'd0;
                    if (maj) begin
                        push_req = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        frame_set = 1'b1;
                        break_set = (shreg_q == 8'h00);
                        state_d   = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                cnt_d = 16'd0;
                if (rxs_q) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 16'd0;
            bit_idx_q <= 3'd0;
            shreg_q   <= 8'h00;
            samp_q    <= 2'b11;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            samp_q    <= samp_d;
        end
    end

    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       mem_d [DEPTH];
    logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
    logic             fifo_empty;
    logic             fifo_full;
    logic             do_pop;
    logic             do_push;
    logic             ovf_set;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                        (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    assign do_pop     = !fifo_empty && rx_ready;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign do_push    = push_req && (!fifo_full || do_pop);
    assign ovf_set    = push_req && fifo_full && !do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[FIFO_AW-1:0]] = shreg_q;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    logic frame_err_q, frame_err_d;
    logic overflow_q, overflow_d;
    logic break_det_q, break_det_d;

    // Clear first so a same-cycle error event wins over err_clr.
    always_comb begin
        frame_err_d = err_clr ? 1'b0 : frame_err_q;
        overflow_d  = err_clr ? 1'b0 : overflow_q;
        break_det_d = err_clr ? 1'b0 : break_det_q;
        if (frame_set) frame_err_d = 1'b1;
        if (ovf_set)   overflow_d  = 1'b1;
        if (break_set) break_det_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            break_det_q <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            break_det_q <= break_det_d;
        end
    end

    assign rx_data   = mem_q[rd_ptr_q[FIFO_AW-1:0]];
    assign rx_valid  = !fifo_empty;
    assign rx_level  = wr_ptr_q - rd_ptr_q;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;
    assign break_det = break_det_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: drives 8N1 frames on rs232_rx and checks received bytes
// through an expected-byte queue, plus level and sticky-flag behaviour.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    localparam int CPB     = 100;
    localparam int AW      = 4;
    localparam int BIT_NS  = CPB * 10;

    logic          clk;
    logic          rst_n;
    logic          rs232_rx;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [AW:0]   rx_level;
    logic          frame_err;
    logic          overflow;
    logic          break_det;
    logic          err_clr;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs232_rx  (rs232_rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_level  (rx_level),
        .frame_err (frame_err),
        .overflow  (overflow),
        .break_det (break_det),
        .err_clr   (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks;
    int         n_errors;
    int         pop_cnt;
    logic [7:0] exp_q[$];
    logic [8:0] exp_b;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Consumer side: every accepted byte is popped against the expected queue.
    always @(negedge clk) begin
        if (rst_n && rx_valid && rx_ready) begin
            exp_b = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
            check_eq("rx_byte", {23'h0, 1'b0, rx_data}, {23'h0, exp_b});
            pop_cnt++;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int bit_ns, input logic stop_v,
                             input int glitch_bit);
        rs232_rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rs232_rx = b[i];
            if (i == glitch_bit) begin
                #(bit_ns / 2);
                rs232_rx = ~b[i];
                #10;
                rs232_rx = b[i];
                #(bit_ns - bit_ns / 2 - 10);
            end else begin
                #(bit_ns);
            end
        end
        rs232_rx = stop_v;
        #(bit_ns);
        rs232_rx = 1'b1;
    endtask

    task automatic pulse_err_clr();
        @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        pop_cnt  = 0;
        rst_n    = 1'b0;
        rs232_rx = 1'b1;
        rx_ready = 1'b1;
        err_clr  = 1'b0;

        // Reset values
        wait_clks(4);
        check_eq("rst_valid", {31'h0, rx_valid}, 0);
        check_eq("rst_level", {27'h0, rx_level}, 0);
        check_eq("rst_data", {24'h0, rx_data}, 0);
        check_eq("rst_frame", {31'h0, frame_err}, 0);
        check_eq("rst_ovf", {31'h0, overflow}, 0);
        check_eq("rst_break", {31'h0, break_det}, 0);
        rst_n = 1'b1;
        wait_clks(5);

        // Single byte, consumer always ready
        exp_q.push_back(8'h41);
        send_byte(8'h41, BIT_NS, 1'b1, -1);
        wait_clks(2 * CPB);
        check_eq("t1_pops", pop_cnt, 1);
        check_eq("t1_level", {27'h0, rx_level}, 0);
        check_eq("t1_flags", {29'h0, frame_err, overflow, break_det}, 0);

        // 17 back-to-back bytes into a 16-deep FIFO with the consumer stalled
        @(posedge clk);
        #1 rx_ready = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) exp_q.push_back(8'(i));
            send_byte(8'(i), BIT_NS, 1'b1, -1);
        end
        wait_clks(2 * CPB);
        check_eq("t2_level_full", {27'h0, rx_level}, 16);
        check_eq("t2_ovf", {31'h0, overflow}, 1);
        check_eq("t2_frame", {31'h0, frame_err}, 0);
        check_eq("t2_valid", {31'h0, rx_valid}, 1);
        @(posedge clk);
        #1 rx_ready = 1'b1;
        wait_clks(30);
        check_eq("t2_pops", pop_cnt, 17);
        check_eq("t2_level_empty", {27'h0, rx_level}, 0);
        pulse_err_clr();
        wait_clks(1);
        check_eq("t2_ovf_clr", {31'h0, overflow}, 0);

        // Stop bit forced low
        send_byte(8'h52, BIT_NS, 1'b0, -1);
        wait_clks(2 * CPB);
        check_eq("t3_frame", {31'h0, frame_err}, 1);
        check_eq("t3_break", {31'h0, break_det}, 0);
        check_eq("t3_level", {27'h0, rx_level}, 0);
        check_eq("t3_pops", pop_cnt, 17);
        pulse_err_clr();
        wait_clks(1);
        check_eq("t3_frame_clr", {31'h0, frame_err}, 0);

        // Line held low for 15 bit times
        rs232_rx = 1'b0;
        #(15 * BIT_NS);
        rs232_rx = 1'b1;
        wait_clks(2 * CPB);
        check_eq("t4_break", {31'h0, break_det}, 1);
        check_eq("t4_frame", {31'h0, frame_err}, 1);
        check_eq("t4_level", {27'h0, rx_level}, 0);
        check_eq("t4_fsm_idle", 32'(dut.state_q), 0);
        exp_q.push_back(8'h77);
        send_byte(8'h77, BIT_NS, 1'b1, -1);
        wait_clks(2 * CPB);
        check_eq("t4_pops", pop_cnt, 18);
        pulse_err_clr();
        wait_clks(1);
        check_eq("t4_clr", {30'h0, frame_err, break_det}, 0);

        // Short glitch on the idle line, then a single-clock glitch inside a frame
        rs232_rx = 1'b0;
        #300;
        rs232_rx = 1'b1;
        wait_clks(2 * CPB);
        check_eq("t5_glitch_pops", pop_cnt, 18);
        check_eq("t5_glitch_level", {27'h0, rx_level}, 0);
        check_eq("t5_glitch_flags", {29'h0, frame_err, overflow, break_det}, 0);
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, BIT_NS, 1'b1, 2);
        wait_clks(2 * CPB);
        check_eq("t5_a5_pops", pop_cnt, 19);

        // Reset in the middle of a frame; the tail of 0xF0 is all ones
        fork
            send_byte(8'hF0, BIT_NS, 1'b1, -1);
            begin
                #(BIT_NS * 5 / 2);
                rst_n = 1'b0;
                #30;
                check_eq("t6_rst_valid", {31'h0, rx_valid}, 0);
                #(BIT_NS * 53 / 10 - BIT_NS * 5 / 2 - 30);
                rst_n = 1'b1;
            end
        join
        wait_clks(2 * CPB);
        check_eq("t6_after_rst_level", {27'h0, rx_level}, 0);
        check_eq("t6_after_rst_flags", {29'h0, frame_err, overflow, break_det}, 0);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, BIT_NS, 1'b1, -1);
        wait_clks(2 * CPB);
        check_eq("t6_3c_pops", pop_cnt, 20);

        // Baud skew of -3% and +3%
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, BIT_NS * 97 / 100, 1'b1, -1);
        wait_clks(2 * CPB);
        exp_q.push_back(8'hC3);
        send_byte(8'hC3, BIT_NS * 103 / 100, 1'b1, -1);
        wait_clks(2 * CPB);
        check_eq("t6_skew_pops", pop_cnt, 22);
        check_eq("t6_skew_flags", {29'h0, frame_err, overflow, break_det}, 0);

        check_eq("sb_left", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
